// File: rtl/selec_color_paleta.sv
// selec_color_paleta: registered VGA pixel-colour generator.
// Picks blank / background / palette foreground each cycle, with a writable
// palette (write-through on read-during-write) and a frame-locked blink mask.
module selec_color_paleta #(
    parameter int CW           = 8,
    parameter int NCOL         = 4,
    parameter int BLINK_FRAMES = 30,
    parameter logic [CW-1:0] BG_R = CW'(0),
    parameter logic [CW-1:0] BG_G = CW'(255),
    parameter logic [CW-1:0] BG_B = CW'(0),
    parameter logic [CW-1:0] FG_R = CW'(127),
    parameter logic [CW-1:0] FG_G = CW'(127),
    parameter logic [CW-1:0] FG_B = CW'(0),
    localparam int IW = $clog2(NCOL)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            video_on,
    input  logic            frame_tick,
    input  logic            Seleccion_color,
    input  logic [IW-1:0]   fg_idx,
    input  logic            blink_en,
    input  logic            pal_we,
    input  logic [IW-1:0]   pal_addr,
    input  logic [3*CW-1:0] pal_data,
    output logic [CW-1:0]   R,
    output logic [CW-1:0]   G,
    output logic [CW-1:0]   B,
    output logic            pix_valid
);

    localparam logic [3*CW-1:0] BG_RGB = {BG_R, BG_G, BG_B};
    localparam logic [3*CW-1:0] FG_RGB = {FG_R, FG_G, FG_B};
    // One extra bit so NCOL itself is representable for range checks
    localparam logic [IW:0]     NCOL_W = NCOL[IW:0];
    localparam int              CNTW   = $clog2(BLINK_FRAMES + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BLINK_FRAMES - 1);

    logic [3*CW-1:0] r_pal [NCOL];
    logic [CNTW-1:0] r_blink_cnt;
    logic            r_blink_phase;
    logic [3*CW-1:0] r_rgb;
    logic            r_valid;

    logic            w_wr_ok;
    logic            w_idx_ok;
    logic [3*CW-1:0] w_pal_rd;
    logic [3*CW-1:0] w_fg;
    logic [3*CW-1:0] w_rgb_next;

    // Palette lookup with write-through forwarding and output priority select
    always_comb begin
        w_wr_ok  = pal_we && ({1'b0, pal_addr} < NCOL_W);
        w_idx_ok = ({1'b0, fg_idx} < NCOL_W);
        w_pal_rd = BG_RGB;
        for (int i = 0; i < NCOL; i++) begin
            if (fg_idx == IW'(i)) begin
                w_pal_rd = r_pal[i];
            end
        end
        if (w_wr_ok && (pal_addr == fg_idx)) begin
            w_fg = pal_data;
        end else begin
            w_fg = w_pal_rd;
        end
        if (!video_on) begin
            w_rgb_next = '0;
        end else if (!Seleccion_color) begin
            w_rgb_next = BG_RGB;
        end else if (blink_en && r_blink_phase) begin
            w_rgb_next = BG_RGB;
        end else if (!w_idx_ok) begin
            w_rgb_next = BG_RGB;
        end else begin
            w_rgb_next = w_fg;
        end
    end

    // Palette storage: reset to the default foreground, writes to valid addresses only
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCOL; i++) begin
            if (reset) begin
                r_pal[i] <= FG_RGB;
            end else if (w_wr_ok && (pal_addr == IW'(i))) begin
                r_pal[i] <= pal_data;
            end
        end
    end

    // Blink timebase: counts frame ticks regardless of blink_en, toggles phase on wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (r_blink_cnt == CNT_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Output register: one cycle of latency for colour and valid flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_rgb   <= w_rgb_next;
            r_valid <= video_on;
        end
    end

    assign R         = r_rgb[3*CW-1:2*CW];
    assign G         = r_rgb[2*CW-1:CW];
    assign B         = r_rgb[CW-1:0];
    assign pix_valid = r_valid;

endmodule

// File: tb/tb_selec_color_paleta.sv
// Directed bench for selec_color_paleta with NCOL=3, BLINK_FRAMES=2.
module tb_selec_color_paleta;

    localparam int CW = 8;
    localparam int NCOL = 3;
    localparam int IW = $clog2(NCOL);

    localparam logic [23:0] BGC = 24'h00FF00;
    localparam logic [23:0] FGC = 24'h7F7F00;
    localparam logic [23:0] RED = 24'hFF0000;

    logic            clk = 1'b0;
    logic            reset;
    logic            video_on;
    logic            frame_tick;
    logic            Seleccion_color;
    logic [IW-1:0]   fg_idx;
    logic            blink_en;
    logic            pal_we;
    logic [IW-1:0]   pal_addr;
    logic [3*CW-1:0] pal_data;
    logic [CW-1:0]   R, G, B;
    logic            pix_valid;

    int n_checks = 0;
    int n_errors = 0;

    selec_color_paleta #(.CW(CW), .NCOL(NCOL), .BLINK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .video_on(video_on), .frame_tick(frame_tick),
        .Seleccion_color(Seleccion_color), .fg_idx(fg_idx), .blink_en(blink_en),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .R(R), .G(G), .B(B), .pix_valid(pix_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rgb(input string tag, input logic [23:0] exp);
        check(tag, {8'h00, R, G, B}, {8'h00, exp});
    endtask

    // One frame: tick pulse, then check the colour that follows it, then idle out the frame
    task automatic frame(input string tag, input logic [23:0] exp);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        check_rgb(tag, exp);
        for (int k = 0; k < 8; k++) step();
    endtask

    initial begin
        reset = 1'b1; video_on = 1'b0; frame_tick = 1'b0; Seleccion_color = 1'b0;
        fg_idx = '0; blink_en = 1'b0; pal_we = 1'b1; pal_addr = 2'd2; pal_data = 24'h123456;

        // 1: reset beats pal_we, then default palette entry shows
        step(); step(); step();
        check_rgb("reset_rgb", 24'h000000);
        check("reset_valid", {31'd0, pix_valid}, 32'd0);
        reset = 1'b0; pal_we = 1'b0;
        video_on = 1'b1; Seleccion_color = 1'b1; fg_idx = 2'd2;
        step();
        check_rgb("fg_default", FGC);
        check("valid_on", {31'd0, pix_valid}, 32'd1);

        // 2: background and blanking
        Seleccion_color = 1'b0;
        step();
        check_rgb("bg", BGC);
        video_on = 1'b0;
        step();
        check_rgb("blank_rgb", 24'h000000);
        check("blank_valid", {31'd0, pix_valid}, 32'd0);

        // 3: write-through forwarding and persistence
        video_on = 1'b1; Seleccion_color = 1'b1; fg_idx = 2'd1;
        pal_we = 1'b1; pal_addr = 2'd1; pal_data = RED;
        step();
        check_rgb("fwd", RED);
        pal_we = 1'b0; pal_data = 24'h0;
        step();
        check_rgb("readback1", RED);
        fg_idx = 2'd0;
        step();
        check_rgb("entry0_untouched", FGC);

        // 4: out-of-range index and ignored write
        fg_idx = 2'd3;
        step();
        check_rgb("idx_oor", BGC);
        pal_we = 1'b1; pal_addr = 2'd3; pal_data = 24'hABCDEF;
        step();
        check_rgb("idx_oor_wr", BGC);
        pal_we = 1'b0;
        fg_idx = 2'd0; step(); check_rgb("after_oor_e0", FGC);
        fg_idx = 2'd1; step(); check_rgb("after_oor_e1", RED);
        fg_idx = 2'd2; step(); check_rgb("after_oor_e2", FGC);

        // 5: blink with BLINK_FRAMES=2
        blink_en = 1'b1;
        step();
        check_rgb("blink_t0", FGC);
        frame("blink_t1", FGC);
        frame("blink_t2", BGC);
        frame("blink_t3", BGC);
        frame("blink_t4", FGC);
        frame("blink_t5", FGC);
        frame("blink_t6", BGC);
        blink_en = 1'b0;
        step();
        check_rgb("noblink_ph1", FGC);
        frame("noblink_t7", FGC);
        frame("noblink_t8", FGC);

        // 6: reset one tick before a toggle restarts the timebase
        blink_en = 1'b1;
        frame("pre_rst_t9", FGC);
        reset = 1'b1;
        step();
        check_rgb("midrst_rgb", 24'h000000);
        check("midrst_valid", {31'd0, pix_valid}, 32'd0);
        reset = 1'b0;
        step();
        check_rgb("post_rst", FGC);
        fg_idx = 2'd1;
        step();
        check_rgb("pal_reset_e1", FGC);
        fg_idx = 2'd2;
        frame("post_rst_tA", FGC);
        frame("post_rst_tB", BGC);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
